// File: rtl/rob_commit_pkg.sv
// Shared Tomasulo definitions: opcodes, ROB sizing, entry layout, op classes.
// Optional build macro for the ROB: ROB_BYPASS_EN (CDB-to-commit forwarding).
package tomasulo_pkg;

    localparam int DEPTH  = 8;
    localparam int IDX_W  = 3;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_LD   = 4'b0100;
    localparam logic [3:0] OP_ST   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b0110;
    localparam logic [3:0] OP_BNEQ = 4'b0111;

    typedef enum logic [1:0] {
        CL_REG,
        CL_STORE,
        CL_BRANCH
    } op_class_t;

    typedef struct packed {
        logic              valid;
        logic              ready;
        logic [3:0]        func;
        logic [3:0]        rd;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              taken;
    } rob_entry_t;

    // Retirement class of an opcode: register write, memory write, or branch
    function automatic op_class_t classify(input logic [3:0] f);
        op_class_t c;
        case (f)
            OP_ST:           c = CL_STORE;
            OP_BEQ, OP_BNEQ: c = CL_BRANCH;
            default:         c = CL_REG;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rob_commit_if.sv
// Issue/CDB/retire bundle between the ROB and its neighbours.
// master = issue, CDB and regbank/memory side; slave = ROB.
interface rob_commit_if;
    import tomasulo_pkg::*;

    logic              alloc_valid;
    logic              alloc_ready;
    logic [3:0]        alloc_func;
    logic [3:0]        alloc_rd;
    logic [IDX_W-1:0]  alloc_idx;
    logic              cdb_valid;
    logic [IDX_W-1:0]  cdb_rob;
    logic [DATA_W-1:0] cdb_data;
    logic [ADDR_W-1:0] cdb_addr;
    logic              cdb_taken;
    logic              commit_valid;
    logic              commit_ready;
    logic [IDX_W-1:0]  commit_rob;
    logic [3:0]        commit_rd;
    logic [DATA_W-1:0] commit_data;
    logic              commit_we;
    logic              commit_mem_we;
    logic [ADDR_W-1:0] commit_addr;
    logic              flush;
    logic [3:0]        flush_target;
    logic [IDX_W:0]    count;

    modport master (
        output alloc_valid, alloc_func, alloc_rd,
        output cdb_valid, cdb_rob, cdb_data, cdb_addr, cdb_taken,
        output commit_ready,
        input  alloc_ready, alloc_idx,
        input  commit_valid, commit_rob, commit_rd, commit_data,
        input  commit_we, commit_mem_we, commit_addr,
        input  flush, flush_target, count
    );

    modport slave (
        input  alloc_valid, alloc_func, alloc_rd,
        input  cdb_valid, cdb_rob, cdb_data, cdb_addr, cdb_taken,
        input  commit_ready,
        output alloc_ready, alloc_idx,
        output commit_valid, commit_rob, commit_rd, commit_data,
        output commit_we, commit_mem_we, commit_addr,
        output flush, flush_target, count
    );
endinterface

// File: rtl/rob_commit_ptr.sv
// Wrapping ROB pointer with increment and synchronous clear.
// Used for both head and tail.
module rob_ptr #(
    parameter int W = 3
) (
    input  logic         clk1,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_ptr
);
    logic [W-1:0] r_ptr;

    // Clear wins over increment; natural wrap at 2**W
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst)        r_ptr <= '0;
        else if (i_clr) r_ptr <= '0;
        else if (i_inc) r_ptr <= r_ptr + 1'b1;
    end

    assign o_ptr = r_ptr;
endmodule

// File: rtl/rob_commit.sv
// 8-entry reorder buffer: allocation, CDB capture, in-order retire, branch flush.
// Build macro ROB_BYPASS_EN forwards a head-tag CDB write straight to commit.
module rob_commit
    import tomasulo_pkg::*;
(
    input  logic         clk1,
    input  logic         rst,
    rob_commit_if.slave  bus
);
    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

    rob_entry_t        r_ent [DEPTH];
    logic [IDX_W:0]    r_count;
    logic              r_flush;
    logic [3:0]        r_flush_target;

    logic [IDX_W-1:0]  w_head;
    logic [IDX_W-1:0]  w_tail;
    rob_entry_t        w_hd;
    logic              w_byp;
    logic              w_cv;
    logic [DATA_W-1:0] w_data;
    logic [ADDR_W-1:0] w_addr;
    logic              w_taken;
    op_class_t         w_cls;
    logic              w_retire;
    logic              w_flush_now;
    logic              w_alloc;

    assign w_hd = r_ent[w_head];

`ifdef ROB_BYPASS_EN
    assign w_byp = bus.cdb_valid && (bus.cdb_rob == w_head) && w_hd.valid;
`else
    assign w_byp = 1'b0;
`endif

    // Head view, optionally overlaid with the CDB broadcast for the head tag
    always_comb begin
        w_data  = w_hd.data;
        w_addr  = w_hd.addr;
        w_taken = w_hd.taken;
        if (w_byp) begin
            w_data  = bus.cdb_data;
            w_addr  = bus.cdb_addr;
            w_taken = bus.cdb_taken;
        end
    end

    assign w_cv        = w_hd.valid && (w_hd.ready || w_byp);
    assign w_cls       = classify(w_hd.func);
    assign w_retire    = w_cv && bus.commit_ready;
    assign w_flush_now = w_retire && (w_cls == CL_BRANCH) && w_taken;

    assign bus.alloc_ready = (r_count != FULL_CNT) && !w_flush_now;
    assign w_alloc         = bus.alloc_valid && bus.alloc_ready;
    assign bus.alloc_idx   = w_tail;

    assign bus.commit_valid  = w_cv;
    assign bus.commit_rob    = w_head;
    assign bus.commit_rd     = w_cv ? w_hd.rd : 4'd0;
    assign bus.commit_data   = w_cv ? w_data : '0;
    assign bus.commit_addr   = w_cv ? w_addr : '0;
    assign bus.commit_we     = w_cv && (w_cls == CL_REG);
    assign bus.commit_mem_we = w_cv && (w_cls == CL_STORE);

    assign bus.flush        = r_flush;
    assign bus.flush_target = r_flush_target;
    assign bus.count        = r_count;

    rob_ptr #(.W(IDX_W)) u_head (
        .clk1  (clk1),
        .rst   (rst),
        .i_inc (w_retire),
        .i_clr (w_flush_now),
        .o_ptr (w_head)
    );

    rob_ptr #(.W(IDX_W)) u_tail (
        .clk1  (clk1),
        .rst   (rst),
        .i_inc (w_alloc),
        .i_clr (w_flush_now),
        .o_ptr (w_tail)
    );

    // Entry array: flush drops everything, else CDB capture, retire, allocate
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
        end else if (w_flush_now) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i].valid <= 1'b0;
                r_ent[i].ready <= 1'b0;
            end
        end else begin
            if (bus.cdb_valid && r_ent[bus.cdb_rob].valid) begin
                r_ent[bus.cdb_rob].data  <= bus.cdb_data;
                r_ent[bus.cdb_rob].addr  <= bus.cdb_addr;
                r_ent[bus.cdb_rob].taken <= bus.cdb_taken;
                r_ent[bus.cdb_rob].ready <= 1'b1;
            end
            if (w_retire) begin
                r_ent[w_head].valid <= 1'b0;
                r_ent[w_head].ready <= 1'b0;
            end
            if (w_alloc) begin
                r_ent[w_tail].valid <= 1'b1;
                r_ent[w_tail].ready <= 1'b0;
                r_ent[w_tail].func  <= bus.alloc_func;
                r_ent[w_tail].rd    <= bus.alloc_rd;
            end
        end
    end

    // Occupancy: alloc and retire in the same cycle cancel out
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst)              r_count <= '0;
        else if (w_flush_now) r_count <= '0;
        else if (w_alloc && !w_retire) r_count <= r_count + 1'b1;
        else if (w_retire && !w_alloc) r_count <= r_count - 1'b1;
    end

    // One-cycle flush pulse; target held until the next taken branch
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_flush        <= 1'b0;
            r_flush_target <= 4'd0;
        end else begin
            r_flush <= w_flush_now;
            if (w_flush_now) r_flush_target <= w_hd.rd;
        end
    end
endmodule

// File: tb/tb_rob_commit.sv
// Directed testbench for rob_commit (default build, no CDB bypass).
// Inputs change 1ns after posedge; outputs sampled 4ns after posedge.
module tb_rob_commit;
    import tomasulo_pkg::*;

    logic clk1;
    logic rst;
    int   checks;
    int   errors;

    rob_commit_if bus ();

    rob_commit u_dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic idle();
        bus.alloc_valid  = 1'b0;
        bus.alloc_func   = 4'd0;
        bus.alloc_rd     = 4'd0;
        bus.cdb_valid    = 1'b0;
        bus.cdb_rob      = '0;
        bus.cdb_data     = '0;
        bus.cdb_addr     = '0;
        bus.cdb_taken    = 1'b0;
        bus.commit_ready = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic alloc(input logic [3:0] f, input logic [3:0] rd);
        bus.alloc_valid = 1'b1;
        bus.alloc_func  = f;
        bus.alloc_rd    = rd;
        cyc();
        bus.alloc_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #3;
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        checks++; if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got %b exp 1", bus.alloc_ready); end
        checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit_valid got %b exp 0", bus.commit_valid); end
        checks++; if (bus.flush !== 1'b0 || bus.flush_target !== 4'd0) begin errors++; $display("FAIL reset_flush got %b/%0d exp 0/0", bus.flush, bus.flush_target); end
        checks++; if (bus.alloc_idx !== 3'd0) begin errors++; $display("FAIL reset_alloc_idx got %0d exp 0", bus.alloc_idx); end
        checks++; if (bus.commit_we !== 1'b0 || bus.commit_mem_we !== 1'b0 || bus.commit_data !== 16'h0) begin errors++; $display("FAIL reset_commit got we=%b mwe=%b d=%h exp 0", bus.commit_we, bus.commit_mem_we, bus.commit_data); end
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        bus.alloc_valid = 1'b1;
        bus.alloc_func  = OP_ADD;
        bus.alloc_rd    = 4'd3;
        #3;
        checks++; if (bus.alloc_idx !== 3'd0) begin errors++; $display("FAIL basic_idx got %0d exp 0", bus.alloc_idx); end
        cyc();
        idle();
        bus.cdb_valid = 1'b1;
        bus.cdb_rob   = 3'd0;
        bus.cdb_data  = 16'h00AB;
        #3;
        checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL basic_count1 got %0d exp 1", bus.count); end
        checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL basic_no_early got %b exp 0", bus.commit_valid); end
        cyc();
        idle();
        bus.commit_ready = 1'b1;
        #3;
        checks++; if (bus.commit_valid !== 1'b1 || bus.commit_we !== 1'b1) begin errors++; $display("FAIL basic_commit got v=%b we=%b exp 1/1", bus.commit_valid, bus.commit_we); end
        checks++; if (bus.commit_rd !== 4'd3 || bus.commit_data !== 16'h00AB) begin errors++; $display("FAIL basic_rd_data got %0d/%h exp 3/00ab", bus.commit_rd, bus.commit_data); end
        checks++; if (bus.commit_rob !== 3'd0 || bus.commit_mem_we !== 1'b0) begin errors++; $display("FAIL basic_rob got %0d/%b exp 0/0", bus.commit_rob, bus.commit_mem_we); end
        cyc();
        idle();
        #3;
        checks++; if (bus.count !== 4'd0 || bus.commit_valid !== 1'b0) begin errors++; $display("FAIL basic_drained got %0d/%b exp 0/0", bus.count, bus.commit_valid); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) alloc(OP_ADD, 4'(i));
        bus.alloc_valid = 1'b1;
        bus.alloc_rd    = 4'd9;
        bus.cdb_valid   = 1'b1;
        bus.cdb_rob     = 3'd0;
        bus.cdb_data    = 16'h0055;
        #3;
        checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", bus.count); end
        checks++; if (bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", bus.alloc_ready); end
        cyc();
        bus.cdb_valid    = 1'b0;
        bus.commit_ready = 1'b1;
        #3;
        checks++; if (bus.commit_valid !== 1'b1 || bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL full_retire_nopass got v=%b ar=%b exp 1/0", bus.commit_valid, bus.alloc_ready); end
        checks++; if (bus.commit_data !== 16'h0055 || bus.commit_rd !== 4'd0) begin errors++; $display("FAIL full_retire_data got %h/%0d exp 0055/0", bus.commit_data, bus.commit_rd); end
        cyc();
        idle();
        #3;
        checks++; if (bus.count !== 4'd7) begin errors++; $display("FAIL full_count7 got %0d exp 7", bus.count); end
        checks++; if (bus.alloc_ready !== 1'b1 || bus.alloc_idx !== 3'd0) begin errors++; $display("FAIL full_wrap got ar=%b idx=%0d exp 1/0", bus.alloc_ready, bus.alloc_idx); end
        checks++; if (bus.commit_valid !== 1'b0 || bus.commit_rob !== 3'd1) begin errors++; $display("FAIL full_head got v=%b rob=%0d exp 0/1", bus.commit_valid, bus.commit_rob); end
    endtask

    task automatic test_order();
        logic [15:0] exp_d [3];
        exp_d[0] = 16'h0010;
        exp_d[1] = 16'h0011;
        exp_d[2] = 16'h0022;
        do_reset();
        alloc(OP_SUB, 4'd1);
        alloc(OP_MUL, 4'd2);
        alloc(OP_LD, 4'd3);
        bus.commit_ready = 1'b1;
        for (int k = 2; k >= 0; k--) begin
            bus.cdb_valid = 1'b1;
            bus.cdb_rob   = 3'(k);
            bus.cdb_data  = exp_d[k];
            #3;
            checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL order_wait%0d got %b exp 0", k, bus.commit_valid); end
            cyc();
        end
        bus.cdb_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #3;
            checks++; if (bus.commit_valid !== 1'b1 || bus.commit_rob !== 3'(k)) begin errors++; $display("FAIL order_tag%0d got v=%b rob=%0d exp 1/%0d", k, bus.commit_valid, bus.commit_rob, k); end
            checks++; if (bus.commit_data !== exp_d[k] || bus.commit_rd !== 4'(k + 1) || bus.commit_we !== 1'b1) begin errors++; $display("FAIL order_data%0d got %h/%0d/%b exp %h/%0d/1", k, bus.commit_data, bus.commit_rd, bus.commit_we, exp_d[k], k + 1); end
            cyc();
        end
        #3;
        checks++; if (bus.count !== 4'd0 || bus.commit_valid !== 1'b0) begin errors++; $display("FAIL order_empty got %0d/%b exp 0/0", bus.count, bus.commit_valid); end
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        alloc(OP_BEQ, 4'd5);
        alloc(OP_ADD, 4'd7);
        bus.cdb_valid = 1'b1;
        bus.cdb_rob   = 3'd0;
        bus.cdb_taken = 1'b1;
        cyc();
        bus.cdb_valid    = 1'b0;
        bus.commit_ready = 1'b1;
        bus.alloc_valid  = 1'b1;
        bus.alloc_func   = OP_ADD;
        bus.alloc_rd     = 4'd9;
        #3;
        checks++; if (bus.commit_valid !== 1'b1 || bus.commit_we !== 1'b0 || bus.commit_mem_we !== 1'b0) begin errors++; $display("FAIL flush_branch got v=%b we=%b mwe=%b exp 1/0/0", bus.commit_valid, bus.commit_we, bus.commit_mem_we); end
        checks++; if (bus.alloc_ready !== 1'b0 || bus.flush !== 1'b0) begin errors++; $display("FAIL flush_block got ar=%b fl=%b exp 0/0", bus.alloc_ready, bus.flush); end
        cyc();
        bus.alloc_valid = 1'b0;
        bus.cdb_valid   = 1'b1;
        bus.cdb_rob     = 3'd1;
        bus.cdb_data    = 16'h0077;
        bus.cdb_taken   = 1'b0;
        #3;
        checks++; if (bus.flush !== 1'b1 || bus.flush_target !== 4'd5) begin errors++; $display("FAIL flush_pulse got %b/%0d exp 1/5", bus.flush, bus.flush_target); end
        checks++; if (bus.count !== 4'd0 || bus.alloc_idx !== 3'd0 || bus.commit_rob !== 3'd0) begin errors++; $display("FAIL flush_ptrs got c=%0d t=%0d h=%0d exp 0/0/0", bus.count, bus.alloc_idx, bus.commit_rob); end
        cyc();
        idle();
        bus.commit_ready = 1'b1;
        #3;
        checks++; if (bus.flush !== 1'b0 || bus.flush_target !== 4'd5) begin errors++; $display("FAIL flush_hold got %b/%0d exp 0/5", bus.flush, bus.flush_target); end
        checks++; if (bus.commit_valid !== 1'b0 || bus.count !== 4'd0) begin errors++; $display("FAIL flush_squash got v=%b c=%0d exp 0/0", bus.commit_valid, bus.count); end
        cyc();
        idle();
    endtask

    task automatic test_store();
        do_reset();
        alloc(OP_ST, 4'd0);
        bus.cdb_valid = 1'b1;
        bus.cdb_rob   = 3'd0;
        bus.cdb_data  = 16'h1234;
        bus.cdb_addr  = 8'h40;
        cyc();
        idle();
        #3;
        checks++; if (bus.commit_mem_we !== 1'b1 || bus.commit_we !== 1'b0) begin errors++; $display("FAIL store_we got mwe=%b we=%b exp 1/0", bus.commit_mem_we, bus.commit_we); end
        checks++; if (bus.commit_addr !== 8'h40 || bus.commit_data !== 16'h1234) begin errors++; $display("FAIL store_addr_data got %h/%h exp 40/1234", bus.commit_addr, bus.commit_data); end
        bus.commit_ready = 1'b1;
        cyc();
        idle();
        #3;
        checks++; if (bus.count !== 4'd0 || bus.commit_mem_we !== 1'b0) begin errors++; $display("FAIL store_done got %0d/%b exp 0/0", bus.count, bus.commit_mem_we); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        for (int i = 0; i < 4; i++) alloc(OP_ADD, 4'(i));
        bus.cdb_valid = 1'b1;
        bus.cdb_rob   = 3'd0;
        bus.cdb_data  = 16'hBEEF;
        cyc();
        idle();
        #1;
        checks++; if (bus.count !== 4'd4 || bus.commit_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %0d/%b exp 4/1", bus.count, bus.commit_valid); end
        rst = 1'b1;
        #1;
        checks++; if (bus.count !== 4'd0 || bus.commit_valid !== 1'b0 || bus.flush !== 1'b0) begin errors++; $display("FAIL rstmid_async got c=%0d v=%b f=%b exp 0/0/0", bus.count, bus.commit_valid, bus.flush); end
        checks++; if (bus.alloc_ready !== 1'b1 || bus.alloc_idx !== 3'd0) begin errors++; $display("FAIL rstmid_alloc got %b/%0d exp 1/0", bus.alloc_ready, bus.alloc_idx); end
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle();
        #1;
        test_reset();
        test_basic();
        test_full();
        test_order();
        test_flush();
        test_store();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
